// File: rtl/render_sequencer.sv
// render_sequencer: walks every draw layer with a nonzero item count, issuing
// one draw request per item and waiting for the datapath to finish each one.
// After a pass it holds until the next frame tick, then re-latches the counts
// and starts the next pass. A free-running frame/step tick generator runs
// while the sequencer is busy. A frame tick that lands mid-pass flags overrun.
module render_sequencer #(
    parameter int NUM_LAYERS      = 4,
    parameter int ITEM_W          = 3,
    parameter int TICK_DIV        = 833333,
    parameter int FRAMES_PER_STEP = 15,
    localparam int LAYER_W        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic [NUM_LAYERS*ITEM_W-1:0] layer_count,
    input  logic                         draw_done,
    output logic                         draw_req,
    output logic [LAYER_W-1:0]           layer_id,
    output logic [ITEM_W-1:0]            item_id,
    output logic                         pass_done,
    output logic                         frame_tick,
    output logic                         step_tick,
    output logic                         busy,
    output logic                         overrun
);

    localparam int CNT_W  = NUM_LAYERS * ITEM_W;
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STEP_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);
    localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
    localparam logic [ITEM_W-1:0]  ITEM_ONE  = ITEM_W'(1);
    localparam logic [ITEM_W:0]    ITEM_ONE_X = (ITEM_W+1)'(1);
    localparam logic [LAYER_W:0]   LAYER_ONE_X = (LAYER_W+1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ISSUE,
        WAIT,
        NEXT,
        HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    counts_q, counts_d;
    logic [LAYER_W-1:0]  layer_q, layer_d;
    logic [ITEM_W-1:0]   item_q, item_d;
    logic                pass_q, pass_d;
    logic                overrun_q, overrun_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [STEP_W-1:0]   step_q, step_d;

    // Priority search / current-layer helpers
    logic [CNT_W-1:0]    search_src;
    logic [LAYER_W:0]    search_from;
    logic                search_hit;
    logic [LAYER_W-1:0]  search_layer;
    logic [ITEM_W-1:0]   cur_count;
    logic                item_last;
    logic                tick_w;

    // Outputs are straight register taps (or decodes of the state register).
    assign busy       = (state_q != IDLE);
    assign draw_req   = (state_q == ISSUE);
    assign layer_id   = layer_q;
    assign item_id    = item_q;
    assign pass_done  = pass_q;
    assign overrun    = overrun_q;
    assign tick_w     = busy && (div_q == DIV_LAST);
    assign frame_tick = tick_w;
    assign step_tick  = tick_w && (step_q == STEP_LAST);

    // Find the lowest nonzero layer at or above search_from in one cycle.
    // LATCH searches the live input (it is being captured this same cycle);
    // NEXT searches the latched copy, starting just above the current layer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        search_src   = (state_q == LATCH) ? layer_count : counts_q;
        search_from  = (state_q == LATCH) ? '0 : ({1'b0, layer_q} + LAYER_ONE_X);
        search_hit   = 1'b0;
        search_layer = '0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if ((k >= int'(search_from)) && (search_src[k*ITEM_W +: ITEM_W] != '0)) begin
                search_hit   = 1'b1;
                search_layer = LAYER_W'(k);
            end
        end
    end

    // Latched item count of the layer being drawn, and whether item_q is its last item.
    always_comb begin
        cur_count = '0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (layer_q == LAYER_W'(k)) begin
                cur_count = counts_q[k*ITEM_W +: ITEM_W];
            end
        end
        item_last = (({1'b0, item_q} + ITEM_ONE_X) >= {1'b0, cur_count});
    end

    // Frame divider and step counter: held at zero in IDLE, free-running while busy.
    always_comb begin
        div_d  = div_q;
        step_d = step_q;
        if (state_q == IDLE) begin
            div_d  = '0;
            step_d = '0;
        end else begin
            div_d = (div_q == DIV_LAST) ? '0 : (div_q + DIV_ONE);
            if (tick_w) begin
                step_d = (step_q == STEP_LAST) ? '0 : (step_q + STEP_ONE);
            end
        end
    end

    // Sequencer next-state and datapath-register updates.
    always_comb begin
        state_d   = state_q;
        counts_d  = counts_q;
        layer_d   = layer_q;
        item_d    = item_q;
        pass_d    = 1'b0;
        overrun_d = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LATCH;
                    overrun_d = 1'b0;
                end
            end
            LATCH: begin
                counts_d = layer_count;
                item_d   = '0;
                if (search_hit) begin
                    layer_d = search_layer;
                    state_d = ISSUE;
                end else begin
                    pass_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (draw_done) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (!item_last) begin
                    item_d  = item_q + ITEM_ONE;
                    state_d = ISSUE;
                end else if (search_hit) begin
                    layer_d = search_layer;
                    item_d  = '0;
                    state_d = ISSUE;
                end else begin
                    pass_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // stop wins over a simultaneous frame tick
                if (stop) begin
                    state_d = IDLE;
                end else if (tick_w) begin
                    state_d = LATCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A tick while a pass is still in flight means the pass ran long.
        if (tick_w && (state_q inside {LATCH, ISSUE, WAIT, NEXT})) begin
            overrun_d = 1'b1;
        end
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state_q   <= IDLE;
            // NOTE: the latched count bank is reset too, so a pass can never
            // observe stale counts from before the reset.
            counts_q  <= '0;
            layer_q   <= '0;
            item_q    <= '0;
            pass_q    <= 1'b0;
            overrun_q <= 1'b0;
            div_q     <= '0;
            step_q    <= '0;
        end else begin
            state_q   <= state_d;
            counts_q  <= counts_d;
            layer_q   <= layer_d;
            item_q    <= item_d;
            pass_q    <= pass_d;
            overrun_q <= overrun_d;
            div_q     <= div_d;
            step_q    <= step_d;
        end
    end

endmodule

// File: tb/tb_render_sequencer.sv
// Directed bench for render_sequencer with NUM_LAYERS=3, ITEM_W=2,
// TICK_DIV=20, FRAMES_PER_STEP=3. Cycle numbers are counted from the
// clock edge that samples start (cycle 0 is the LATCH cycle).
module tb_render_sequencer;

    logic       clock;
    logic       reset;
    logic       start;
    logic       stop;
    logic [5:0] layer_count;
    logic       draw_done;
    logic       draw_req;
    logic [1:0] layer_id;
    logic [1:0] item_id;
    logic       pass_done;
    logic       frame_tick;
    logic       step_tick;
    logic       busy;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic seen_req;

    render_sequencer #(
        .NUM_LAYERS      (3),
        .ITEM_W          (2),
        .TICK_DIV        (20),
        .FRAMES_PER_STEP (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .layer_count (layer_count),
        .draw_done   (draw_done),
        .draw_req    (draw_req),
        .layer_id    (layer_id),
        .item_id     (item_id),
        .pass_done   (pass_done),
        .frame_tick  (frame_tick),
        .step_tick   (step_tick),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic check_draw(input string tag, input int lay, input int itm);
        check({tag, "_req"},   32'(draw_req), 1);
        check({tag, "_layer"}, 32'(layer_id), lay);
        check({tag, "_item"},  32'(item_id),  itm);
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        layer_count = '0;
        draw_done   = 1'b0;
        #1;
        check("rst_busy",     32'(busy),       0);
        check("rst_req",      32'(draw_req),   0);
        check("rst_pass",     32'(pass_done),  0);
        check("rst_frame",    32'(frame_tick), 0);
        check("rst_overrun",  32'(overrun),    0);
        check("rst_ids",      32'({layer_id, item_id}), 0);
        step();
        step();
        reset = 1'b0;
        step();
        check("idle_busy", 32'(busy), 0);

        // ---- pass over {L0=2, L1=0, L2=1}, counts changed mid-pass ----
        layer_count = 6'b01_00_10;
        do_start();
        check("p1_latch_busy", 32'(busy), 1);
        check("p1_latch_req",  32'(draw_req), 0);
        go_to(1);  check_draw("p1_d0", 0, 0);
        go_to(2);  check("p1_wait_req", 32'(draw_req), 0);
        layer_count = 6'b11_11_11;
        go_to(3);  draw_done = 1'b1;
        go_to(4);  draw_done = 1'b0;
        go_to(5);  check_draw("p1_d1", 0, 1);
        go_to(7);  draw_done = 1'b1;
        go_to(8);  draw_done = 1'b0;
        go_to(9);  check_draw("p1_d2", 2, 0);
        go_to(11); draw_done = 1'b1;
        go_to(12); draw_done = 1'b0;
        check("p1_next_pass", 32'(pass_done), 0);
        go_to(13); check("p1_pass_done", 32'(pass_done), 1);
        go_to(14);
        check("p1_pass_pulse", 32'(pass_done), 0);
        check("p1_hold_busy",  32'(busy), 1);
        check("p1_no_overrun", 32'(overrun), 0);
        stop = 1'b1;
        go_to(15);
        stop = 1'b0;
        check("p1_stop_busy", 32'(busy), 0);

        // ---- empty pass, tick timing, stop vs frame_tick ----
        layer_count = '0;
        do_start();
        check("e_latch_busy", 32'(busy), 1);
        seen_req = 1'b0;
        while (cyc < 81) begin
            step();
            if (draw_req) seen_req = 1'b1;
            if (cyc == 1)  check("e_pass_done", 32'(pass_done), 1);
            if (cyc == 2)  check("e_pass_pulse", 32'(pass_done), 0);
            if (cyc == 18) check("e_frame_early", 32'(frame_tick), 0);
            if (cyc == 19) begin
                check("e_frame19", 32'(frame_tick), 1);
                check("e_step19",  32'(step_tick), 0);
            end
            if (cyc == 20) check("e_frame_pulse", 32'(frame_tick), 0);
            if (cyc == 21) check("e_relatch_pass", 32'(pass_done), 1);
            if (cyc == 39) begin
                check("e_frame39", 32'(frame_tick), 1);
                check("e_step39",  32'(step_tick), 0);
            end
            if (cyc == 58) check("e_frame58", 32'(frame_tick), 0);
            if (cyc == 59) begin
                check("e_frame59", 32'(frame_tick), 1);
                check("e_step59",  32'(step_tick), 1);
            end
            if (cyc == 79) begin
                check("e_frame79", 32'(frame_tick), 1);
                check("e_step79",  32'(step_tick), 0);
                stop = 1'b1;
            end
            if (cyc == 80) begin
                stop = 1'b0;
                check("e_stop_busy",  32'(busy), 0);
                check("e_stop_frame", 32'(frame_tick), 0);
            end
            if (cyc == 81) begin
                check("e_no_relatch_busy", 32'(busy), 0);
                check("e_no_relatch_pass", 32'(pass_done), 0);
            end
        end
        check("e_no_draw_req", 32'(seen_req), 0);
        check("e_no_overrun",  32'(overrun), 0);

        // ---- overrun: draw_done withheld 25 cycles ----
        layer_count = 6'b00_00_01;
        do_start();
        go_to(1);  check_draw("o_d0", 0, 0);
        go_to(19);
        check("o_tick_in_wait", 32'(frame_tick), 1);
        check("o_before_tick",  32'(overrun), 0);
        go_to(20); check("o_set", 32'(overrun), 1);
        go_to(26); draw_done = 1'b1;
        go_to(27); draw_done = 1'b0;
        go_to(28);
        check("o_pass_done", 32'(pass_done), 1);
        check("o_sticky28",  32'(overrun), 1);
        go_to(30); check("o_no_early_latch", 32'(draw_req), 0);
        go_to(41);
        check_draw("o_next_pass", 0, 0);
        check("o_sticky41", 32'(overrun), 1);
        go_to(42); draw_done = 1'b1;
        go_to(43); draw_done = 1'b0;
        go_to(44);
        check("o_pass2_done", 32'(pass_done), 1);
        stop = 1'b1;
        go_to(45);
        stop = 1'b0;
        check("o_idle_busy",   32'(busy), 0);
        check("o_idle_sticky", 32'(overrun), 1);

        // ---- start clears overrun; reset in WAIT aborts ----
        layer_count = 6'b11_00_01;
        do_start();
        check("r_start_clears", 32'(overrun), 0);
        go_to(1); check_draw("r_d0", 0, 0);
        go_to(2); draw_done = 1'b1;
        go_to(3); draw_done = 1'b0;
        go_to(4); check_draw("r_d1", 2, 0);
        go_to(5); draw_done = 1'b1;
        go_to(6); draw_done = 1'b0;
        go_to(7); check_draw("r_d2", 2, 1);
        go_to(8);
        check("r_wait_layer", 32'(layer_id), 2);
        reset = 1'b1;
        #1;
        check("r_async_busy",  32'(busy), 0);
        check("r_async_ids",   32'({layer_id, item_id}), 0);
        check("r_async_req",   32'(draw_req), 0);
        check("r_async_pass",  32'(pass_done), 0);
        check("r_async_frame", 32'(frame_tick), 0);
        step();
        reset = 1'b0;
        seen_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (busy || pass_done || draw_req) seen_req = 1'b1;
        end
        check("r_stays_idle", 32'(seen_req), 0);
        do_start();
        go_to(1); check_draw("r_restart", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/render_sequencer.md
RENDER_SEQUENCER -- requirements
Module: render_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, meaning number of draw layers visited per pass.
REQ-002 SHALL have parameter ITEM_W, default 3, meaning width of the per-layer item index (up to 2^ITEM_W-1 items per layer).
REQ-003 SHALL have parameter TICK_DIV, default 833333, meaning clock cycles per frame tick (60 Hz at 50 MHz).
REQ-004 SHALL have parameter FRAMES_PER_STEP, default 15, meaning frame ticks per step tick.
REQ-005 SHALL derive LAYER_W = max(1, clog2(NUM_LAYERS)).
REQ-006 SHALL use clock and reset as follows: reset reset, asynchronous, active-high; clock clock.
REQ-007 SHALL have ports, listed as name, direction, width, meaning:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- start  in  1  begin continuous pass operation; ignored unless IDLE
- stop  in  1  return to IDLE at next HOLD
- layer_count  in  NUM_LAYERS*ITEM_W  item count per layer, layer k in bits [k*ITEM_W +: ITEM_W]; 0 = skip layer
- draw_done  in  1  datapath finished current item
- draw_req  out  1  one-cycle pulse, draw item (layer_id, item_id)
- layer_id  out  LAYER_W  current layer
- item_id  out  ITEM_W  current item
- pass_done  out  1  one-cycle pulse, all layers drawn
- frame_tick  out  1  one-cycle pulse every TICK_DIV cycles while running
- step_tick  out  1  one-cycle pulse every FRAMES_PER_STEP frame ticks
- busy  out  1  high in any state except IDLE
- overrun  out  1  sticky: frame tick arrived before pass finished

Function
REQ-008 SHALL implement states IDLE, LATCH, ISSUE, WAIT, NEXT, HOLD.
REQ-009 IDLE: start=1 -> LATCH; tick divider and step counter held at 0; overrun cleared on start.
REQ-010 LATCH: capture layer_count into internal register; select lowest layer with nonzero count, item 0 -> ISSUE; if all counts 0 -> pulse pass_done, -> HOLD.
REQ-011 ISSUE: draw_req=1 for exactly this cycle -> WAIT.
REQ-012 WAIT: hold layer_id/item_id; draw_done=1 -> NEXT; draw_done outside WAIT is ignored.
REQ-013 NEXT: if item_id < latched count-1, item_id+1 -> ISSUE; else advance to next higher layer with nonzero latched count, item 0 -> ISSUE; if none remains, pulse pass_done -> HOLD.
REQ-014 HOLD: stop=1 -> IDLE (stop takes priority over frame_tick in the same cycle); else frame_tick=1 -> LATCH; else remain.
REQ-015 Changes to layer_count during a pass SHALL have no effect until the next LATCH.
REQ-016 Tick divider: counts 0..TICK_DIV-1 while busy, wraps to 0; frame_tick=1 in the cycle the counter equals TICK_DIV-1.
REQ-017 Step counter: counts frame_ticks 0..FRAMES_PER_STEP-1, wraps; step_tick coincides with the frame_tick that wraps it.
REQ-018 frame_tick in LATCH, ISSUE, WAIT or NEXT SHALL set overrun; the pass continues, and the next LATCH waits for the following frame_tick.
REQ-019 layer_id, item_id SHALL be registered; they are valid whenever draw_req or WAIT.
REQ-020 Layer skipping SHALL cost no extra cycles: NEXT selects the next nonzero layer in one cycle (priority search).

Reset
REQ-021 reset=1 SHALL immediately force IDLE, with draw_req, pass_done, frame_tick, step_tick, busy, overrun = 0, layer_id = item_id = 0, and the divider, step counter and latched counts = 0.
REQ-022 Reset asserted mid-pass SHALL abort without emitting pass_done; operation resumes only after a new start.

Verification (NUM_LAYERS=3, ITEM_W=2, TICK_DIV=20, FRAMES_PER_STEP=3)
REQ-023 counts {L0=2, L1=0, L2=1}, start, draw_done 2 cycles after each draw_req -> draw_req sequence (0,0),(0,1),(2,0), then pass_done, then HOLD.
REQ-024 counts all 0, start -> pass_done 1 cycle after LATCH, no draw_req, next LATCH on frame_tick.
REQ-025 running 60 cycles -> frame_tick at cycles 19, 39, 59 after start; step_tick only at cycle 59.
REQ-026 draw_done withheld 25 cycles -> overrun=1 after the first frame_tick and stays 1 until the next start.
REQ-027 stop and frame_tick in the same HOLD cycle -> IDLE, busy=0, no new LATCH.
REQ-028 reset pulse during WAIT -> all outputs 0 at once; start then restarts at layer 0, item 0.
